// File: rtl/fp16_mul_arb_pkg.sv
// Shared FP16 field layout, special constants and classification helpers
// for the arbitrated FP16 multiplier.
package fp16_mul_arb_pkg;

    localparam int FP_W    = 16;
    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int MUL_LAT = 2;

    localparam logic [FP_W-1:0]  QNAN     = 16'h7C01;
    localparam logic [EXP_W-1:0] EXP_MAX  = 5'h1F;
    localparam logic signed [7:0] EXP_BIAS = 8'sd15;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    function automatic logic is_nan(input fp16_t x);
        return (x.exp == EXP_MAX) && (x.man != 10'h000);
    endfunction

    function automatic logic is_inf(input fp16_t x);
        return (x.exp == EXP_MAX) && (x.man == 10'h000);
    endfunction

    // Subnormal operands are flushed, so any zero exponent reads as zero.
    function automatic logic is_zero(input fp16_t x);
        return (x.exp == 5'h00);
    endfunction

endpackage

// File: rtl/fp16_mul_arb_mul.sv
// Two-stage FP16 multiplier: decode/multiply, then normalise and
// round-to-nearest-even. Subnormals flush to signed zero.
import fp16_mul_arb_pkg::*;

module fp16_mul (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] y
);

    fp16_t              fa_s, fb_s;
    logic               sign_d, sign_q;
    logic               spec_d, spec_q;
    logic [FP_W-1:0]    spec_val_d, spec_val_q;
    logic signed [7:0]  exp_d, exp_q;
    logic [21:0]        prod_d, prod_q;
    logic signed [7:0]  exp_n_s;
    logic [MAN_W-1:0]   man_t_s;
    logic               guard_s, sticky_s;
    logic [MAN_W:0]     man_r_s;
    logic [FP_W-1:0]    y_d, y_q;

    // Stage 1: classify operands and form the full significand product.
    always_comb begin
        fa_s       = fp16_t'(a);
        fb_s       = fp16_t'(b);
        sign_d     = fa_s.sign ^ fb_s.sign;
        spec_d     = 1'b1;
        spec_val_d = QNAN;
        prod_d     = 22'({1'b1, fa_s.man}) * 22'({1'b1, fb_s.man});
        exp_d      = $signed({3'b000, fa_s.exp}) + $signed({3'b000, fb_s.exp}) - EXP_BIAS;
        if (is_nan(fa_s) || is_nan(fb_s) ||
            (is_inf(fa_s) && is_zero(fb_s)) || (is_inf(fb_s) && is_zero(fa_s))) begin
            spec_val_d = QNAN;
        end else if (is_inf(fa_s) || is_inf(fb_s)) begin
            spec_val_d = {sign_d, EXP_MAX, 10'h000};
        end else if (is_zero(fa_s) || is_zero(fb_s)) begin
            spec_val_d = {sign_d, 15'h0000};
        end else begin
            spec_d = 1'b0;
        end
    end

    // Stage 2: normalise, round to nearest even, then saturate or flush.
    always_comb begin
        if (prod_q[21]) begin
            man_t_s  = prod_q[20:11];
            guard_s  = prod_q[10];
            sticky_s = |prod_q[9:0];
            exp_n_s  = exp_q + 8'sd1;
        end else begin
            man_t_s  = prod_q[19:10];
            guard_s  = prod_q[9];
            sticky_s = |prod_q[8:0];
            exp_n_s  = exp_q;
        end
        man_r_s = {1'b0, man_t_s} + {10'h000, guard_s & (sticky_s | man_t_s[0])};
        if (man_r_s[MAN_W]) begin
            exp_n_s = exp_n_s + 8'sd1;
        end else begin
            exp_n_s = exp_n_s;
        end
        if (spec_q) begin
            y_d = spec_val_q;
        end else if (exp_n_s > 8'sd30) begin
            y_d = {sign_q, EXP_MAX, 10'h000};
        end else if (exp_n_s < 8'sd1) begin
            y_d = {sign_q, 15'h0000};
        end else begin
            y_d = {sign_q, exp_n_s[EXP_W-1:0], man_r_s[MAN_W-1:0]};
        end
    end

    // Pipeline registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 16'h0000;
            exp_q      <= 8'sd0;
            prod_q     <= 22'h000000;
            y_q        <= 16'h0000;
        end else begin
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            exp_q      <= exp_d;
            prod_q     <= prod_d;
            y_q        <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/fp16_mul_arb.sv
// Round-robin arbiter sharing one pipelined FP16 multiplier among
// NUM_REQ requesters; results return tagged to the owner 3 cycles after accept.
import fp16_mul_arb_pkg::*;

module fp16_mul_arb #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]         rsp_data,
    output logic                    busy,
    output logic [CNT_W-1:0]        issue_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               found_s, acc_s;
    logic [IDX_W-1:0]   ptr_d, ptr_q;
    logic               iss_v_d, iss_v_q;
    logic [IDX_W-1:0]   iss_idx_d, iss_idx_q;
    logic [FP_W-1:0]    iss_a_d, iss_a_q, iss_b_d, iss_b_q;
    logic [MUL_LAT-1:0] tag_v_d, tag_v_q;
    logic [IDX_W-1:0]   tag_idx_d [MUL_LAT];
    logic [IDX_W-1:0]   tag_idx_q [MUL_LAT];
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    // Grant the first valid requester at or above the pointer, wrapping around.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && en && !rst && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                found_s = 1'b1;
                gnt_s[(int'(ptr_q) + k) % NUM_REQ] = 1'b1;
                gnt_idx_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end else begin
                found_s = found_s;
            end
        end
        acc_s = found_s;
    end

    // Next-state for pointer, issue stage, tag shift register and counter.
    always_comb begin
        ptr_d     = ptr_q;
        iss_v_d   = acc_s;
        iss_idx_d = iss_idx_q;
        iss_a_d   = iss_a_q;
        iss_b_d   = iss_b_q;
        cnt_d     = cnt_q;
        if (acc_s) begin
            ptr_d     = IDX_W'((int'(gnt_idx_s) + 1) % NUM_REQ);
            iss_idx_d = gnt_idx_s;
            iss_a_d   = req_a[int'(gnt_idx_s)*FP_W +: FP_W];
            iss_b_d   = req_b[int'(gnt_idx_s)*FP_W +: FP_W];
            cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ptr_d = ptr_q;
        end
        tag_v_d      = {tag_v_q[MUL_LAT-2:0], iss_v_q};
        tag_idx_d[0] = iss_idx_q;
        for (int i = 1; i < MUL_LAT; i++) begin
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    // State registers; reset drops every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            iss_v_q   <= 1'b0;
            iss_idx_q <= '0;
            iss_a_q   <= 16'h0000;
            iss_b_q   <= 16'h0000;
            tag_v_q   <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            iss_v_q   <= iss_v_d;
            iss_idx_q <= iss_idx_d;
            iss_a_q   <= iss_a_d;
            iss_b_q   <= iss_b_d;
            tag_v_q   <= tag_v_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_idx_q[i] <= tag_idx_d[i];
            end
        end
    end

    fp16_mul u_mul (
        .clk   (clk),
        .rst_n (~rst),
        .a     (iss_a_q),
        .b     (iss_b_q),
        .y     (rsp_data)
    );

    // Route the returning result to its owner only when the final tag is live.
    always_comb begin
        rsp_valid = '0;
        if (tag_v_q[MUL_LAT-1]) begin
            rsp_valid[tag_idx_q[MUL_LAT-1]] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    assign req_ready = gnt_s;
    assign busy      = iss_v_q | (|tag_v_q);
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_fp16_mul_arb.sv
// Randomised scoreboard bench for fp16_mul_arb: a behavioural arbiter and
// real-arithmetic FP16 reference predict grants, counters and tagged results.
module tb_fp16_mul_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = 64'h0;
    logic [63:0] req_b = 64'h0;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic [3:0]  issue_cnt;

    fp16_mul_arb #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; logic [15:0] data; int due; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    bit   acc_log[int];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ptr_m = 0;
    int   cnt_m = 0;
    int   gnt_last = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Product rounded to nearest even from exact real arithmetic; subnormals flush.
    function automatic logic [15:0] fp16_ref(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, e, q;
        logic s;
        bit nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        real x, fr;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        nan_a = (ea == 31) && (ma != 0); nan_b = (eb == 31) && (mb != 0);
        inf_a = (ea == 31) && (ma == 0); inf_b = (eb == 31) && (mb == 0);
        zer_a = (ea == 0);               zer_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) return 16'h7C01;
        if (inf_a || inf_b) return {s, 15'h7C00};
        if (zer_a || zer_b) return {s, 15'h0000};
        x = real'(1024 + ma) * real'(1024 + mb);
        e = ea + eb - 50;
        while (x >= 2048.0) begin x = x / 2.0; e++; end
        q  = $rtoi(x);
        fr = x - real'(q);
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
        if (q == 2048) begin q = 1024; e++; end
        e = e + 25;
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0)  return {s, 15'h0000};
        return {s, 5'(e), 10'(q - 1024)};
    endfunction

    function automatic logic [15:0] rand_op();
        int r;
        logic [15:0] sp [6];
        sp[0] = 16'h7C00; sp[1] = 16'hFC00; sp[2] = 16'h7C01;
        sp[3] = 16'h0000; sp[4] = 16'h8000; sp[5] = 16'h0123;
        r = $urandom_range(0, 9);
        if (r == 0) return sp[$urandom_range(0, 5)];
        if (r < 4)  return 16'($urandom());
        return {1'($urandom()), 5'($urandom_range(8, 22)), 10'($urandom())};
    endfunction

    // Negedge check of grant, busy and counter against the behavioural arbiter.
    task automatic check_cycle();
        logic [3:0] exp_rdy;
        logic       exp_busy;
        int g;
        g = -1;
        exp_rdy = 4'h0;
        if (!rst && en) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_busy = !rst && (acc_log.exists(cyc - 1) || acc_log.exists(cyc - 2) || acc_log.exists(cyc - 3));
        total++;
        if (req_ready !== exp_rdy) begin
            bad++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
        end
        total++;
        if (busy !== exp_busy) begin
            bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        total++;
        if (issue_cnt !== 4'(cnt_m)) begin
            bad++; $display("FAIL issue_cnt cyc=%0d got=%0d exp=%0d", cyc, issue_cnt, cnt_m);
        end
        if (g >= 0) begin
            sb.push_back('{idx: g, data: fp16_ref(req_a[g*16 +: 16], req_b[g*16 +: 16]), due: cyc + 3});
            acc_log[cyc] = 1'b1;
            ptr_m = (g + 1) % 4;
            cnt_m = (cnt_m + 1) % 16;
        end
        gnt_last = g;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (gnt_last >= 0) req_valid[gnt_last] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'h0;
        sb.delete();
        acc_log.delete();
        ptr_m = 0;
        cnt_m = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((req_valid != 4'h0 || sb.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        total++;
        if (n >= maxc) begin
            bad++; $display("FAIL drain_timeout cyc=%0d pending=%0d valid=%b", cyc, sb.size(), req_valid);
        end
        tick();
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_valid[i] = 1'b1;
    endtask

    // Scoreboard monitor: every response must match the oldest expectation in cycle, owner and data.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            total++; bad++;
            $display("FAIL rsp_missing cyc=%0d got=none exp_idx=%0d due=%0d", cyc, sb[0].idx, sb[0].due);
            void'(sb.pop_front());
        end
        if (rsp_valid !== 4'h0) begin
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL rsp_unexpected cyc=%0d got=%b exp=0000", cyc, rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_valid !== 4'(1 << mon_e.idx) || rsp_data !== mon_e.data || mon_e.due != cyc) begin
                    bad++;
                    $display("FAIL rsp cyc=%0d got=%b/%h exp=%b/%h due=%0d",
                             cyc, rsp_valid, rsp_data, 4'(1 << mon_e.idx), mon_e.data, mon_e.due);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        en = 1'b1;
        tick();

        set_req(0, 16'h3C00, 16'h4000);
        run_idle(20);

        do_reset();
        en = 1'b1;
        set_req(0, 16'h3C00, 16'h3C00);
        set_req(1, 16'h4000, 16'h4000);
        set_req(2, 16'h3E00, 16'h4000);
        set_req(3, 16'h3800, 16'h4400);
        repeat (5) begin
            tick();
            req_valid = 4'hF;
        end
        req_valid = 4'h0;
        run_idle(20);

        set_req(0, 16'h7C01, 16'h3C00);
        set_req(1, 16'h7C00, 16'h0000);
        set_req(2, 16'hFC00, 16'h3C00);
        set_req(3, 16'h8000, 16'h4000);
        run_idle(20);

        en = 1'b0;
        set_req(1, 16'h3C00, 16'h3C00);
        repeat (5) tick();
        en = 1'b1;
        run_idle(20);

        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, rand_op(), rand_op());
                    else req_a[i*16 +: 16] = 16'($urandom());
                end
            end
            en = ($urandom_range(0, 5) != 0);
            tick();
        end
        en = 1'b1;
        req_valid = 4'h0;
        run_idle(30);

        set_req(0, 16'h4000, 16'h4000);
        set_req(1, 16'h4200, 16'h4000);
        tick();
        tick();
        do_reset();
        en = 1'b1;
        repeat (6) tick();
        req_valid = 4'hF;
        tick();
        req_valid = 4'h0;
        run_idle(20);

        do_reset();
        en = 1'b1;
        for (int n = 0; n < 17; n++) begin
            set_req(0, 16'($urandom_range(16'h3000, 16'h4800)), 16'h3C00);
            tick();
        end
        req_valid = 4'h0;
        run_idle(20);
        total++;
        if (issue_cnt !== 4'd1) begin
            bad++; $display("FAIL wrap got=%0d exp=1", issue_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
